// File: rtl/data_mem_responder.sv
// Latency-modelling data memory behind the MEM stage load/store port: one request at a time,
// programmable wait, then a held response. Optional misaligned-access error via MISALIGN_ERR_EN.
module data_mem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | latency countdown; access performed when cnt reaches 0
    // RESP  | response held until resp_ready
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int AW = $clog2(DEPTH);

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            wr_q;
    logic [AW-1:0]   idx_q;
    logic [63:0]     wdata_q;
    logic [63:0]     rdata_q;
    logic            err_q;
    logic            misaligned;
    logic            accept;
    logic            access;
    logic [63:0]     mem [DEPTH];

`ifdef MISALIGN_ERR_EN
    logic [2:0]      lo_q;
    logic            unused_addr;
    assign unused_addr = ^req_addr[63:3+AW];
    assign misaligned  = (lo_q != 3'd0);
`else
    logic            unused_addr;
    assign unused_addr = ^{req_addr[63:3+AW], req_addr[2:0]};
    assign misaligned  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
`ifdef MISALIGN_ERR_EN
            lo_q    <= 3'd0;
`endif
            for (int i = 0; i < DEPTH; i++) mem[i] <= 64'd0;
        end else begin
            if (accept) begin
                cnt     <= 4'(LATENCY);
                wr_q    <= req_write;
                idx_q   <= req_addr[3 +: AW];
                wdata_q <= req_wdata;
`ifdef MISALIGN_ERR_EN
                lo_q    <= req_addr[2:0];
`endif
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            // A store commits here, before its response, so a following load sees it.
            if (access) begin
                if (misaligned) begin
                    rdata_q <= 64'd0;
                    err_q   <= 1'b1;
                end else if (wr_q) begin
                    mem[idx_q] <= wdata_q;
                    rdata_q    <= 64'd0;
                    err_q      <= 1'b0;
                end else begin
                    rdata_q <= mem[idx_q];
                    err_q   <= 1'b0;
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
`ifdef MISALIGN_ERR_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected responses, a monitor
// pops and compares on each accepted response. Expectations follow MISALIGN_ERR_EN if defined.
module tb_data_mem_responder;
    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [64:0] exp_q[$];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
        end
    endtask

    // Monitor: compares every response at the cycle it is accepted.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            logic [64:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got rdata 0x%016h err %0b with nothing expected",
                         resp_rdata, resp_err);
            end else begin
                e = exp_q.pop_front();
                if (resp_rdata !== e[63:0] || resp_err !== e[64]) begin
                    errors++;
                    $display("FAIL resp_data: got rdata 0x%016h err %0b expected rdata 0x%016h err %0b",
                             resp_rdata, resp_err, e[63:0], e[64]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        if (!req_ready) begin
            errors++;
            checks++;
            $display("FAIL %s_ready_timeout: req_ready still 0 after 50 cycles, expected 1", name);
        end
    endtask

    task automatic do_req(input string name, input logic w, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] exp_d,
                          input logic exp_e, input int hold);
        int cyc;
        wait_ready(name);
        exp_q.push_back({exp_e, exp_d});
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = (hold == 0);
        tick();
        if (hold == 0) req_valid = 1'b0;
        check({name, "_busy"}, 64'(busy), 64'd1);
        cyc = 0;
        while (!resp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'(LATENCY + 1));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                check({name, "_hold_valid"}, 64'(resp_valid), 64'd1);
                check({name, "_hold_data"}, resp_rdata, exp_d);
                check({name, "_hold_req_ready"}, 64'(req_ready), 64'd0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        tick();
        check({name, "_resp_one_cycle"}, 64'(resp_valid), 64'd0);
        check({name, "_req_ready_back"}, 64'(req_ready), 64'd1);
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v_beef;
        logic [63:0] v_77;
        logic        e_mis;
        logic [63:0] d_mis;
        v_beef = 64'hDEADBEEF_CAFEF00D;
        v_77   = 64'h77;
`ifdef MISALIGN_ERR_EN
        e_mis = 1'b1;
        d_mis = 64'd0;
`else
        e_mis = 1'b0;
        d_mis = v_beef;
`endif

        repeat (2) tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_err", 64'(resp_err), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_req_ready", 64'(req_ready), 64'd1);

        do_req("load_18",    1'b0, 64'h18,  64'd0,  64'd0,  1'b0, 0);
        do_req("store_20",   1'b1, 64'h20,  v_beef, 64'd0,  1'b0, 0);
        do_req("load_20",    1'b0, 64'h20,  64'd0,  v_beef, 1'b0, 0);
        do_req("store_200",  1'b1, 64'h200, 64'h55, 64'd0,  1'b0, 0);
        do_req("load_0",     1'b0, 64'h0,   64'd0,  64'h55, 1'b0, 0);
        do_req("load_hold",  1'b0, 64'h20,  64'd0,  v_beef, 1'b0, 5);
        do_req("load_high",  1'b0, 64'hFFFF_FFFF_FFFF_FE20, 64'd0, v_beef, 1'b0, 0);
        do_req("load_23",    1'b0, 64'h23,  64'd0,  d_mis,  e_mis, 0);

        // Store interrupted by reset while the latency counter is still running.
        wait_ready("rst_store");
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h40;
        req_wdata = 64'h1234;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        do_req("load_40",    1'b0, 64'h40,  64'd0,  64'd0,  1'b0, 0);

`ifdef MISALIGN_ERR_EN
        do_req("store_mis",  1'b1, 64'h29,  v_77,   64'd0,  1'b1, 0);
        do_req("load_28",    1'b0, 64'h28,  64'd0,  64'd0,  1'b0, 0);
`else
        do_req("store_29",   1'b1, 64'h29,  v_77,   64'd0,  1'b0, 0);
        do_req("load_28",    1'b0, 64'h28,  64'd0,  v_77,   1'b0, 0);
`endif

        repeat (3) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
